dbscan_label_streamer: RTL and testbench
========================================

Name: dbscan_label_streamer

Overview:
Reads back the clustering result held in the DBSCAN point memory once the core FSM finishes. Emits one record per point (index, label, core flag) on a valid/ready output stream. Sits beside dbscan_point_memory on its read side and feeds the host or a UART/debug bridge. It does not write the memory.

Parameters:
N, 16, number of points in point memory (N >= 1)
IDX_W, 4, point index width (2^IDX_W >= N)
LBL_W, 4, cluster label width; label 0 = noise/unassigned

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse (driven from dbscan done rising edge); begins a readout
rd_addr  out  IDX_W  point memory read address
rd_label  in  LBL_W  label at rd_addr, combinational same-cycle read
rd_core  in  1  core flag at rd_addr, combinational same-cycle read
out_valid  out  1  output record valid
out_ready  in  1  consumer accepts record
out_idx  out  IDX_W  record point index
out_label  out  LBL_W  record label
out_core  out  1  record core flag
out_last  out  1  record is index N-1
busy  out  1  readout in progress
stream_done  out  1  one-cycle pulse after final record accepted

Behaviour:
- Clock and reset: one clock clk; reset rst is asynchronous, active-high. Reset values: all outputs 0, state IDLE, counter 0.
- States:
  - IDLE: rd_addr = 0. On start, load output register with {0, rd_label, rd_core}, set out_valid = 1, counter <= 1 → STREAM (or FLUSH if N = 1).
  - STREAM: rd_addr = counter. Output register loads when out_valid = 0 or out_ready = 1. On load: counter increments; record with index N-1 → FLUSH.
  - FLUSH: all reads issued. On out_valid & out_ready: out_valid <= 0, stream_done pulses next cycle → IDLE.
- Handshake:
  - Transfer when out_valid & out_ready.
  - While out_valid = 1 and out_ready = 0, out_idx, out_label, out_core and out_last hold stable.
  - out_valid never drops without a transfer.
- Throughput and latency:
  - Throughput is 1 record per cycle with out_ready held high.
  - First record is valid in the cycle after start.
  - Whole readout completes in N cycles of readiness. stream_done asserts 1 cycle after the last transfer.
- busy: high from the cycle after start until the stream_done cycle inclusive.
- out_last = (out_idx == N-1) & out_valid.
- start while busy is ignored. No restart and no counter change.
- Counter never exceeds N-1 on rd_addr. No wrap past N; addresses N..2^IDX_W-1 are never issued.
- Reset mid-stream: immediate return to IDLE, out_valid = 0, no stream_done pulse.
- start and rst together: rst wins.

Optional Feature:
DBSCAN_STATS_EN
- Enabled: adds outputs noise_cnt (IDX_W+1), core_cnt (IDX_W+1) and max_label (LBL_W).
  - All three clear on start.
  - On each transfer: noise_cnt increments if out_label == 0; core_cnt increments if out_core; max_label = max(max_label, out_label).
  - Values are final and stable when stream_done pulses; held until the next start; reset to 0.
- Disabled: ports and counters absent; streaming behaviour identical.

Decomposition:
- Package dbscan_pkg holds:
  - N, IDX_W, LBL_W
  - NOISE_LABEL = 0
  - state encoding: IDLE = 2'd0, STREAM = 2'd1, FLUSH = 2'd2
- One natural sub-module: dbscan_out_reg, the valid/ready output register holding {idx, label, core, last} with load-enable and hold.
- The FSM/counter stays in the top of this block.

Test Plan:
- Memory labels {1,1,0,2,...}, cores {1,0,0,1,...}, out_ready = 1, start pulse → out_valid the next cycle; 16 consecutive records idx 0..15 with matching label/core; out_last only on idx 15; stream_done 1 cycle after; busy low after.
- out_ready toggled 1,0,0,1,... → no record lost or duplicated; outputs stable during stalls; 16 transfers total in order.
- start re-pulsed at idx 5 → ignored; sequence continues 6..15; single stream_done.
- rst asserted at idx 8 → out_valid = 0 and busy = 0 immediately (async); no stream_done; a new start restarts at idx 0.
- N = 1 build, label 3, core 1, start → one record {0,3,1,last=1}, then stream_done.
- DBSCAN_STATS_EN with 4 noise points, 6 cores, max label 5 → noise_cnt = 4, core_cnt = 6, max_label = 5 at stream_done.

Source files
------------

// File: rtl/dbscan_pkg.sv
// rtl/dbscan_pkg.sv - shared constants and state encoding for the DBSCAN label streamer
package dbscan_pkg;

  localparam int N     = 16;
  localparam int IDX_W = 4;
  localparam int LBL_W = 4;

  // Label value reserved for noise / unassigned points
  localparam int NOISE_LABEL = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

endpackage

// File: rtl/dbscan_out_reg.sv
// rtl/dbscan_out_reg.sv - valid/ready output register for one streamed point record
module dbscan_out_reg
  import dbscan_pkg::*;
#(
  parameter int IDX_W = dbscan_pkg::IDX_W,
  parameter int LBL_W = dbscan_pkg::LBL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             drop,
  input  logic [IDX_W-1:0] d_idx,
  input  logic [LBL_W-1:0] d_label,
  input  logic             d_core,
  input  logic             d_last,
  output logic             q_valid,
  output logic [IDX_W-1:0] q_idx,
  output logic [LBL_W-1:0] q_label,
  output logic             q_core,
  output logic             q_last
);

  // Capture a new record on load, empty on drop, otherwise hold for the consumer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_idx   <= '0;
      q_label <= '0;
      q_core  <= 1'b0;
      q_last  <= 1'b0;
    end else if (load) begin
      q_valid <= 1'b1;
      q_idx   <= d_idx;
      q_label <= d_label;
      q_core  <= d_core;
      q_last  <= d_last;
    end else if (drop) begin
      q_valid <= 1'b0;
      q_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/dbscan_label_streamer.sv
// rtl/dbscan_label_streamer.sv - streams per-point cluster label/core records out of point memory (optional DBSCAN_STATS_EN)
module dbscan_label_streamer #(
  parameter int N     = dbscan_pkg::N,
  parameter int IDX_W = dbscan_pkg::IDX_W,
  parameter int LBL_W = dbscan_pkg::LBL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IDX_W-1:0] rd_addr,
  input  logic [LBL_W-1:0] rd_label,
  input  logic             rd_core,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [LBL_W-1:0] out_label,
  output logic             out_core,
  output logic             out_last,
  output logic             busy,
  output logic             stream_done
`ifdef DBSCAN_STATS_EN
  ,
  output logic [IDX_W:0]   noise_cnt,
  output logic [IDX_W:0]   core_cnt,
  output logic [LBL_W-1:0] max_label
`endif
);

  import dbscan_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t           state;
  logic [IDX_W-1:0] counter;
  logic             load;
  logic             drop;
  logic             transfer;
  logic             rec_last;
  logic             accept_start;

  assign transfer     = out_valid & out_ready;
  assign accept_start = (state == IDLE) & start & ~busy;
  // counter is zero in IDLE and parks on N-1 in FLUSH, so it is always a legal address
  assign rd_addr      = counter;
  assign out_last     = rec_last & out_valid;

  // Decide when the output register takes the record at rd_addr or empties
  always_comb begin
    load = 1'b0;
    drop = 1'b0;
    case (state)
      IDLE:    load = accept_start;
      STREAM:  load = ~out_valid | out_ready;
      FLUSH:   drop = transfer;
      default: ;
    endcase
  end

  dbscan_out_reg #(
    .IDX_W (IDX_W),
    .LBL_W (LBL_W)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .drop    (drop),
    .d_idx   (counter),
    .d_label (rd_label),
    .d_core  (rd_core),
    .d_last  (counter == LAST_IDX),
    .q_valid (out_valid),
    .q_idx   (out_idx),
    .q_label (out_label),
    .q_core  (out_core),
    .q_last  (rec_last)
  );

  // Readout sequencer: address counter, busy window and end-of-stream pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      counter     <= '0;
      busy        <= 1'b0;
      stream_done <= 1'b0;
    end else begin
      stream_done <= 1'b0;
      case (state)
        IDLE: begin
          // busy is still high only in the stream_done cycle; a start there is ignored
          busy <= 1'b0;
          if (accept_start) begin
            busy <= 1'b1;
            if (N == 1) begin
              state <= FLUSH;
            end else begin
              counter <= IDX_W'(1);
              state   <= STREAM;
            end
          end
        end
        STREAM: begin
          if (load) begin
            if (counter == LAST_IDX) begin
              state <= FLUSH;
            end else begin
              counter <= counter + IDX_W'(1);
            end
          end
        end
        FLUSH: begin
          if (transfer) begin
            state       <= IDLE;
            counter     <= '0;
            stream_done <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          counter <= '0;
        end
      endcase
    end
  end

`ifdef DBSCAN_STATS_EN
  // Accumulate noise/core counts and the highest label over accepted records
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      noise_cnt <= '0;
      core_cnt  <= '0;
      max_label <= '0;
    end else if (accept_start) begin
      noise_cnt <= '0;
      core_cnt  <= '0;
      max_label <= '0;
    end else if (transfer) begin
      if (out_label == LBL_W'(NOISE_LABEL)) noise_cnt <= noise_cnt + 1'b1;
      if (out_core) core_cnt <= core_cnt + 1'b1;
      if (out_label > max_label) max_label <= out_label;
    end
  end
`endif

endmodule

// File: tb/tb_dbscan_label_streamer.sv
// tb/tb_dbscan_label_streamer.sv - scoreboard bench for dbscan_label_streamer (N=16 and N=1 instances)
module tb_dbscan_label_streamer;

  typedef struct packed {
    logic [3:0] idx;
    logic [3:0] label;
    logic       core;
    logic       last;
  } rec_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] rd_addr;
  logic [3:0] rd_label;
  logic       rd_core;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_idx;
  logic [3:0] out_label;
  logic       out_core;
  logic       out_last;
  logic       busy;
  logic       stream_done;

  logic       start1;
  logic [0:0] rd_addr1;
  logic [3:0] rd_label1;
  logic       rd_core1;
  logic       out_valid1;
  logic       out_ready1;
  logic [0:0] out_idx1;
  logic [3:0] out_label1;
  logic       out_core1;
  logic       out_last1;
  logic       busy1;
  logic       stream_done1;

`ifdef DBSCAN_STATS_EN
  logic [4:0] noise_cnt;
  logic [4:0] core_cnt;
  logic [3:0] max_label;
  logic [1:0] noise_cnt1;
  logic [1:0] core_cnt1;
  logic [3:0] max_label1;
`endif

  logic [3:0] mem_label [16];
  logic       mem_core  [16];

  rec_t exp_q[$];
  int   total;
  int   bad;
  int   done_seen;
  int   max_addr;

  assign rd_label = mem_label[rd_addr];
  assign rd_core  = mem_core[rd_addr];

  dbscan_label_streamer #(.N(16), .IDX_W(4), .LBL_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .rd_addr     (rd_addr),
    .rd_label    (rd_label),
    .rd_core     (rd_core),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_idx     (out_idx),
    .out_label   (out_label),
    .out_core    (out_core),
    .out_last    (out_last),
    .busy        (busy),
    .stream_done (stream_done)
`ifdef DBSCAN_STATS_EN
    ,
    .noise_cnt   (noise_cnt),
    .core_cnt    (core_cnt),
    .max_label   (max_label)
`endif
  );

  dbscan_label_streamer #(.N(1), .IDX_W(1), .LBL_W(4)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .start       (start1),
    .rd_addr     (rd_addr1),
    .rd_label    (rd_label1),
    .rd_core     (rd_core1),
    .out_valid   (out_valid1),
    .out_ready   (out_ready1),
    .out_idx     (out_idx1),
    .out_label   (out_label1),
    .out_core    (out_core1),
    .out_last    (out_last1),
    .busy        (busy1),
    .stream_done (stream_done1)
`ifdef DBSCAN_STATS_EN
    ,
    .noise_cnt   (noise_cnt1),
    .core_cnt    (core_cnt1),
    .max_label   (max_label1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic push_stream();
    rec_t r;
    for (int i = 0; i < 16; i++) begin
      r.idx   = 4'(i);
      r.label = mem_label[i];
      r.core  = mem_core[i];
      r.last  = (i == 15);
      exp_q.push_back(r);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready high; mode 1: ready pattern 1,0,0,1; mode 2: ready high, start re-pulsed at idx 5
  task automatic run_stream(input int mode);
    int   d0;
    int   k;
    bit   repulsed;
    logic [3:0] pat;
    pat = 4'b1001;
    repulsed = 1'b0;
    d0 = done_seen;
    push_stream();
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("first_valid", int'(out_valid), 1);
    check("busy_after_start", int'(busy), 1);
    k = 0;
    while (done_seen == d0 && k < 300) begin
      out_ready = (mode == 1) ? pat[k[1:0]] : 1'b1;
      start = (mode == 2) && out_valid && (out_idx == 4'd5) && !repulsed;
      if (start) repulsed = 1'b1;
      tick();
      k++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("stream_done_seen", done_seen - d0, 1);
`ifdef DBSCAN_STATS_EN
    check("noise_cnt", int'(noise_cnt), 4);
    check("core_cnt", int'(core_cnt), 6);
    check("max_label", int'(max_label), 5);
`endif
    tick();
    check("busy_after_done", int'(busy), 0);
    check("valid_after_done", int'(out_valid), 0);
    check("queue_drained", exp_q.size(), 0);
    tick();
    tick();
    check("single_done", done_seen - d0, 1);
  endtask

  // Monitor: pops the expected record on every transfer and checks handshake rules
  initial begin
    rec_t e;
    bit   stall_prev;
    bit   done_due;
    logic [3:0] h_idx;
    logic [3:0] h_label;
    logic       h_core;
    logic       h_last;
    stall_prev = 1'b0;
    done_due   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
        done_due   = 1'b0;
        continue;
      end
      if (done_due || stream_done) check("stream_done_timing", int'(stream_done), int'(done_due));
      if (stream_done) done_seen++;
      done_due = 1'b0;
      if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
      if (stall_prev) begin
        check("stall_valid_hold", int'(out_valid), 1);
        check("stall_hold", int'({out_idx, out_label, out_core, out_last}),
              int'({h_idx, h_label, h_core, h_last}));
      end
      if (out_valid) check("last_rule", int'(out_last), int'(out_idx == 4'd15));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_record", int'(out_idx), -1);
        end else begin
          e = exp_q.pop_front();
          check("rec_idx", int'(out_idx), int'(e.idx));
          check("rec_label", int'(out_label), int'(e.label));
          check("rec_core", int'(out_core), int'(e.core));
          check("rec_last", int'(out_last), int'(e.last));
          if (e.last) done_due = 1'b1;
        end
      end
      stall_prev = out_valid && !out_ready;
      h_idx   = out_idx;
      h_label = out_label;
      h_core  = out_core;
      h_last  = out_last;
    end
  end

  initial begin
    int k;
    int d0;
    total = 0;
    bad = 0;
    done_seen = 0;
    max_addr = 0;
    mem_label = '{4'd1, 4'd1, 4'd0, 4'd2, 4'd0, 4'd3, 4'd5, 4'd0,
                  4'd2, 4'd4, 4'd0, 4'd1, 4'd3, 4'd3, 4'd2, 4'd1};
    mem_core  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    start1 = 1'b0;
    out_ready1 = 1'b1;
    rd_label1 = 4'd3;
    rd_core1 = 1'b1;
    tick();
    check("rst_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(stream_done), 0);
    check("rst_addr", int'(rd_addr), 0);
    check("rst_last", int'(out_last), 0);
    tick();
    rst = 1'b0;
    tick();

    run_stream(0);
    run_stream(1);
    run_stream(2);

    // reset in the middle of a stream
    d0 = done_seen;
    push_stream();
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!(out_valid && out_idx == 4'd8) && k < 50) begin
      tick();
      k++;
    end
    check("reached_idx8", int'(out_idx), 8);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_addr", int'(rd_addr), 0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("midrst_no_done", done_seen - d0, 0);
    run_stream(0);

    // single-point instance
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("n1_valid", int'(out_valid1), 1);
    check("n1_rec", int'({out_idx1, out_label1, out_core1, out_last1}), int'({1'b0, 4'd3, 1'b1, 1'b1}));
    check("n1_busy", int'(busy1), 1);
    tick();
    check("n1_valid_drop", int'(out_valid1), 0);
    check("n1_done", int'(stream_done1), 1);
`ifdef DBSCAN_STATS_EN
    check("n1_noise", int'(noise_cnt1), 0);
    check("n1_core", int'(core_cnt1), 1);
    check("n1_max", int'(max_label1), 3);
`endif
    tick();
    check("n1_done_pulse", int'(stream_done1), 0);
    check("n1_busy_end", int'(busy1), 0);

    check("max_rd_addr", max_addr, 15);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
